// File: rtl/seven_seg_scanner.sv
// Multiplexed 3-digit seven-segment scanner: captures BCD digits on load and
// time-multiplexes them over four anode slots with optional leading-zero blanking.
module seven_seg_scanner #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] centenas,
  input  logic [3:0] decenas,
  input  logic [3:0] unidades,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    SLOT_UNITS    = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_OFF      = 2'd3
  } slot_t;

  // load is a one-cycle strobe with no ready: all three digits are sampled
  // on any rising edge where it is high, so the source must hold them valid then.
  logic [CW-1:0] cnt_q, cnt_d;
  slot_t         slot_q, slot_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, units_q, units_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          blank_hund, blank_tens;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_seg = 7'h3F;
      4'd1:    digit_to_seg = 7'h06;
      4'd2:    digit_to_seg = 7'h5B;
      4'd3:    digit_to_seg = 7'h4F;
      4'd4:    digit_to_seg = 7'h66;
      4'd5:    digit_to_seg = 7'h6D;
      4'd6:    digit_to_seg = 7'h7D;
      4'd7:    digit_to_seg = 7'h07;
      4'd8:    digit_to_seg = 7'h7F;
      4'd9:    digit_to_seg = 7'h6F;
      default: digit_to_seg = 7'h40; // non-BCD input shows a dash
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      slot_q  <= SLOT_UNITS;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      an_q    <= '0;
      seg_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    slot_d  = slot_q;
    hund_d  = load ? centenas : hund_q;
    tens_d  = load ? decenas  : tens_q;
    units_d = load ? unidades : units_q;

    if (tick) begin
      case (slot_q)
        SLOT_UNITS:    slot_d = SLOT_TENS;
        SLOT_TENS:     slot_d = SLOT_HUNDREDS;
        SLOT_HUNDREDS: slot_d = SLOT_OFF;
        default:       slot_d = SLOT_UNITS;
      endcase
    end
  end

  // Output stage works active-high; polarity is applied after the register.
  always_comb begin
    blank_hund = (BLANK_LEADING != 0) && (hund_q == 4'd0);
    blank_tens = blank_hund && (tens_q == 4'd0);
    an_d       = 4'b0000;
    seg_d      = 7'h00;
    case (slot_q)
      SLOT_UNITS: begin
        an_d  = 4'b0001;
        seg_d = digit_to_seg(units_q);
      end
      SLOT_TENS: begin
        if (!blank_tens) begin
          an_d  = 4'b0010;
          seg_d = digit_to_seg(tens_q);
        end
      end
      SLOT_HUNDREDS: begin
        if (!blank_hund) begin
          an_d  = 4'b0100;
          seg_d = digit_to_seg(hund_q);
        end
      end
      default: begin
        an_d  = 4'b0000;
        seg_d = 7'h00;
      end
    endcase
  end

  assign an  = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign seg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp  = (ACTIVE_LOW != 0);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: an active-high and an active-low instance share
// stimulus; per-cycle expectations flow through a scoreboard queue.
module tb_seven_seg_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] centenas, decenas, unidades;
  logic       load;
  logic [3:0] an, an_al;
  logic [6:0] seg, seg_al;
  logic       dp, dp_al;

  // {seg_checked, an[3:0], seg[6:0]}, active-high
  logic [11:0] exp_q[$];
  int          n_vec;
  int          n_err;
  int          e;
  logic [3:0]  dh, dt, du;

  seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .centenas(centenas), .decenas(decenas),
    .unidades(unidades), .load(load), .an(an), .seg(seg), .dp(dp)
  );

  seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .centenas(centenas), .decenas(decenas),
    .unidades(unidades), .load(load), .an(an_al), .seg(seg_al), .dp(dp_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d <= 4'd9) seg_of = tbl[d];
    else           seg_of = 7'h40;
  endfunction

  // Expected display for output edge k (k=1 is the first edge after reset release).
  function automatic logic [11:0] exp_val(input int k, input logic [3:0] h, t, u);
    int s;
    s = ((k - 1) / 4) % 4;
    exp_val = {1'b1, 4'b0000, 7'h00};
    if (s == 0) exp_val = {1'b1, 4'b0001, seg_of(u)};
    if (s == 1) exp_val = (h == 0 && t == 0) ? {1'b0, 4'b0000, 7'h00} : {1'b1, 4'b0010, seg_of(t)};
    if (s == 2) exp_val = (h == 0) ? {1'b0, 4'b0000, 7'h00} : {1'b1, 4'b0100, seg_of(h)};
  endfunction

  // One clock: push expectation for this edge, optionally strobe load, then
  // pop and compare the registered outputs just after the edge.
  task automatic step(input bit do_load, input logic [3:0] h, t, u);
    logic [11:0] x;
    exp_q.push_back(exp_val(e, dh, dt, du));
    if (do_load) begin
      centenas = h; decenas = t; unidades = u; load = 1'b1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    if (do_load) begin
      dh = h; dt = t; du = u;
    end
    x = exp_q.pop_front();
    n_vec++;
    if (an !== x[10:7]) begin
      n_err++; $display("FAIL an edge=%0d got=%b exp=%b", e, an, x[10:7]);
    end
    n_vec++;
    if (an_al !== ~x[10:7]) begin
      n_err++; $display("FAIL an_al edge=%0d got=%b exp=%b", e, an_al, ~x[10:7]);
    end
    if (x[11]) begin
      n_vec++;
      if (seg !== x[6:0]) begin
        n_err++; $display("FAIL seg edge=%0d got=%h exp=%h", e, seg, x[6:0]);
      end
      n_vec++;
      if (seg_al !== ~x[6:0]) begin
        n_err++; $display("FAIL seg_al edge=%0d got=%h exp=%h", e, seg_al, ~x[6:0]);
      end
    end
    n_vec++;
    if (dp !== 1'b0 || dp_al !== 1'b1) begin
      n_err++; $display("FAIL dp edge=%0d got=%b/%b exp=0/1", e, dp, dp_al);
    end
    e++;
  endtask

  task automatic restart(input logic [3:0] h, t, u);
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dh = 4'd0; dt = 4'd0; du = 4'd0;
    e = 1;
    step(1'b1, h, t, u);
  endtask

  task automatic run_to(input int last);
    while (e <= last) step(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if (an !== 4'h0 || seg !== 7'h00 || dp !== 1'b0) begin
      n_err++; $display("FAIL reset_ah got=%b/%h/%b exp=0000/00/0", an, seg, dp);
    end
    n_vec++;
    if (an_al !== 4'hF || seg_al !== 7'h7F || dp_al !== 1'b1) begin
      n_err++; $display("FAIL reset_al got=%b/%h/%b exp=1111/7f/1", an_al, seg_al, dp_al);
    end
    restart(4'd0, 4'd0, 4'd0);
    run_to(8);
  endtask

  task automatic test_scan_123;
    restart(4'd1, 4'd2, 4'd3);
    run_to(33);
  endtask

  task automatic test_blank_007;
    restart(4'd0, 4'd0, 4'd7);
    run_to(17);
  endtask

  task automatic test_blank_050;
    restart(4'd0, 4'd5, 4'd0);
    run_to(17);
  endtask

  task automatic test_dash;
    restart(4'd12, 4'd3, 4'd4);
    run_to(17);
  endtask

  task automatic test_load_on_tick;
    restart(4'd1, 4'd2, 4'd3);
    run_to(3);
    step(1'b1, 4'd9, 4'd9, 4'd9);
    run_to(17);
  endtask

  task automatic test_load_mid_slot;
    restart(4'd1, 4'd2, 4'd3);
    run_to(5);
    step(1'b1, 4'($urandom_range(1, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)));
    run_to(17);
  endtask

  task automatic test_reset_mid_slot;
    restart(4'd1, 4'd2, 4'd3);
    run_to(9);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (an !== 4'h0 || seg !== 7'h00) begin
      n_err++; $display("FAIL async_reset_ah got=%b/%h exp=0000/00", an, seg);
    end
    n_vec++;
    if (an_al !== 4'hF || seg_al !== 7'h7F || dp_al !== 1'b1) begin
      n_err++; $display("FAIL async_reset_al got=%b/%h/%b exp=1111/7f/1", an_al, seg_al, dp_al);
    end
    restart(4'd1, 4'd2, 4'd3);
    run_to(9);
  endtask

  initial begin
    n_vec = 0; n_err = 0; e = 1;
    dh = 4'd0; dt = 4'd0; du = 4'd0;
    reset = 1'b1; load = 1'b0;
    centenas = 4'd0; decenas = 4'd0; unidades = 4'd0;
    test_reset();
    test_scan_123();
    test_blank_007();
    test_blank_050();
    test_dash();
    test_load_on_tick();
    test_load_mid_slot();
    test_reset_mid_slot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
